// File: rtl/lcd_status_reader.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_reader
// Description : HD44780 read-cycle engine. Performs single status/data reads
//               or busy-polls status reads until BF clears or a poll limit.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_status_reader #(
    parameter int T_AS      = 3,
    parameter int T_EH      = 25,
    parameter int T_AH      = 2,
    parameter int T_REC     = 25,
    parameter int MAX_POLLS = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       poll_req,
    input  logic       rd_rs,
    output logic       rd_ack,
    output logic       rd_done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_counter,
    output logic       timeout,
    output logic       reader_active,
    output logic       lcd_RS,
    output logic       lcd_RW,
    output logic       lcd_E,
    input  logic [7:0] lcd_DB_in
);

    localparam int c_TMAX_A = (T_AS > T_EH) ? T_AS : T_EH;
    localparam int c_TMAX_B = (T_AH > T_REC) ? T_AH : T_REC;
    localparam int c_TMAX   = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
    localparam int TW       = $clog2(c_TMAX + 1);
    localparam int CW       = $clog2(MAX_POLLS + 1);

    localparam logic [TW-1:0] c_AS_LAST  = TW'(T_AS - 1);
    localparam logic [TW-1:0] c_EH_LAST  = TW'(T_EH - 1);
    localparam logic [TW-1:0] c_AH_LAST  = TW'(T_AH - 1);
    localparam logic [TW-1:0] c_REC_LAST = TW'(T_REC - 1);
    localparam logic [CW-1:0] c_MAX_CNT  = CW'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_E_HIGH  = 3'd2,
        S_HOLD    = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tmr;
    logic [CW-1:0] r_cnt;
    logic          r_rs;
    logic          r_poll;
    logic          w_tmr_last;

    always_comb begin
        w_tmr_last = 1'b0;
        case (r_state)
            S_SETUP:   w_tmr_last = (r_tmr == c_AS_LAST);
            S_E_HIGH:  w_tmr_last = (r_tmr == c_EH_LAST);
            S_HOLD:    w_tmr_last = (r_tmr == c_AH_LAST);
            S_RECOVER: w_tmr_last = (r_tmr == c_REC_LAST);
            default:   w_tmr_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_cnt         <= '0;
            r_rs          <= 1'b0;
            r_poll        <= 1'b0;
            rd_ack        <= 1'b0;
            rd_done       <= 1'b0;
            rd_data       <= 8'h00;
            busy_flag     <= 1'b0;
            addr_counter  <= 7'h00;
            timeout       <= 1'b0;
            reader_active <= 1'b0;
            lcd_RS        <= 1'b0;
            lcd_RW        <= 1'b0;
            lcd_E         <= 1'b0;
        end else begin
            rd_ack  <= 1'b0;
            rd_done <= 1'b0;
            r_tmr   <= w_tmr_last ? '0 : r_tmr + TW'(1);
            case (r_state)
                S_IDLE: begin
                    r_tmr <= '0;
                    if (poll_req || rd_req) begin
                        // Polls always read the status register, whatever rd_rs says.
                        r_state       <= S_SETUP;
                        r_poll        <= poll_req;
                        r_rs          <= poll_req ? 1'b0 : rd_rs;
                        lcd_RS        <= poll_req ? 1'b0 : rd_rs;
                        lcd_RW        <= 1'b1;
                        rd_ack        <= 1'b1;
                        reader_active <= 1'b1;
                        timeout       <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_tmr_last) begin
                        r_state <= S_E_HIGH;
                        lcd_E   <= 1'b1;
                    end
                end
                S_E_HIGH: begin
                    if (w_tmr_last) begin
                        r_state <= S_HOLD;
                        lcd_E   <= 1'b0;
                        rd_data <= lcd_DB_in;
                        r_cnt   <= r_cnt + CW'(1);
                        if (!r_rs) begin
                            busy_flag    <= lcd_DB_in[7];
                            addr_counter <= lcd_DB_in[6:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tmr_last) begin
                        if (r_poll && busy_flag && (r_cnt < c_MAX_CNT)) begin
                            r_state <= S_RECOVER;
                            lcd_RS  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            rd_done <= 1'b1;
                            lcd_RW  <= 1'b0;
                            lcd_RS  <= 1'b0;
                            timeout <= r_poll && busy_flag;
                        end
                    end
                end
                S_RECOVER: begin
                    if (w_tmr_last) begin
                        r_state <= S_SETUP;
                    end
                end
                S_DONE: begin
                    r_state       <= S_IDLE;
                    reader_active <= 1'b0;
                    r_tmr         <= '0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tmr         <= '0;
                    reader_active <= 1'b0;
                    lcd_E         <= 1'b0;
                    lcd_RW        <= 1'b0;
                    lcd_RS        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_status_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_status_reader
// Description : Directed vector bench for lcd_status_reader (MAX_POLLS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_status_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req = 1'b0;
    logic       poll_req = 1'b0;
    logic       rd_rs = 1'b0;
    logic       rd_ack, rd_done, busy_flag, timeout, reader_active;
    logic [7:0] rd_data;
    logic [6:0] addr_counter;
    logic       lcd_RS, lcd_RW, lcd_E;
    logic [7:0] lcd_DB_in = 8'h00;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    lcd_status_reader #(
        .T_AS(3), .T_EH(25), .T_AH(2), .T_REC(25), .MAX_POLLS(4)
    ) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .poll_req(poll_req), .rd_rs(rd_rs),
        .rd_ack(rd_ack), .rd_done(rd_done), .rd_data(rd_data), .busy_flag(busy_flag),
        .addr_counter(addr_counter), .timeout(timeout), .reader_active(reader_active),
        .lcd_RS(lcd_RS), .lcd_RW(lcd_RW), .lcd_E(lcd_E), .lcd_DB_in(lcd_DB_in)
    );

    typedef struct {
        logic       rd;
        logic       poll;
        logic       rs;
        logic       mid_req;
        logic [7:0] db_busy;
        int         n_busy;
        logic [7:0] db_final;
        logic       exp_rs;
        logic [7:0] exp_data;
        logic       exp_bf;
        logic [6:0] exp_ac;
        logic       exp_to;
        int         exp_pulses;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mkv(input logic rd, poll, rs, mid, input logic [7:0] dbb,
                                 input int nb, input logic [7:0] dbf, input logic ers,
                                 input logic [7:0] ed, input logic ebf, input logic [6:0] eac,
                                 input logic eto, input int ep, input int el);
        vec_t v;
        v.rd = rd; v.poll = poll; v.rs = rs; v.mid_req = mid;
        v.db_busy = dbb; v.n_busy = nb; v.db_final = dbf; v.exp_rs = ers;
        v.exp_data = ed; v.exp_bf = ebf; v.exp_ac = eac; v.exp_to = eto;
        v.exp_pulses = ep; v.exp_lat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat = 0, pulses = 0, e_cyc = 0, rw_cyc = 0, rs_bad = 0, e_no_rw = 0;
        int   extra_ack = 0, post = 0;
        logic prev_e = 1'b0;
        bit   finished = 0;
        @(negedge clk);
        lcd_DB_in = (v.n_busy > 0) ? v.db_busy : v.db_final;
        rd_req = v.rd; poll_req = v.poll; rd_rs = v.rs;
        @(negedge clk);
        chk($sformatf("v%0d ack", idx), rd_ack, 1);
        chk($sformatf("v%0d timeout_clear_on_accept", idx), timeout, 0);
        rd_req = 1'b0; poll_req = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (c > 0 && rd_ack) extra_ack++;
            if (lcd_E) e_cyc++;
            if (lcd_RW) rw_cyc++;
            if (lcd_E && lcd_RS !== v.exp_rs) rs_bad++;
            if (lcd_E && !lcd_RW) e_no_rw++;
            if (prev_e && !lcd_E) pulses++;
            prev_e = lcd_E;
            lcd_DB_in = (pulses < v.n_busy) ? v.db_busy : v.db_final;
            if (rd_done) begin
                finished = 1;
                break;
            end
            if (v.mid_req) rd_req = (lat == 10);
            @(negedge clk);
            lat++;
        end
        rd_req = 1'b0;
        chk($sformatf("v%0d done_seen", idx), finished, 1);
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d e_pulses", idx), pulses, v.exp_pulses);
        chk($sformatf("v%0d e_high_cycles", idx), e_cyc, 25 * v.exp_pulses);
        chk($sformatf("v%0d rw_high_cycles", idx), rw_cyc, v.exp_lat);
        chk($sformatf("v%0d rs_during_e", idx), rs_bad, 0);
        chk($sformatf("v%0d e_without_rw", idx), e_no_rw, 0);
        chk($sformatf("v%0d extra_ack", idx), extra_ack, 0);
        chk($sformatf("v%0d rd_data", idx), rd_data, v.exp_data);
        chk($sformatf("v%0d busy_flag", idx), busy_flag, v.exp_bf);
        chk($sformatf("v%0d addr_counter", idx), addr_counter, v.exp_ac);
        chk($sformatf("v%0d timeout", idx), timeout, v.exp_to);
        chk($sformatf("v%0d active_at_done", idx), reader_active, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rd_done || rd_ack) post++;
        end
        chk($sformatf("v%0d no_extra_op", idx), post, 0);
        chk($sformatf("v%0d idle_inactive", idx), reader_active, 0);
    endtask

    initial begin
        int   dones;
        bit   saw_e;
        vec_t vr;

        //             rd poll rs mid  dbb  nb dbf   ers data  bf ac     to pls lat
        vecs[0] = mkv(1, 0, 0, 0, 8'h00, 0, 8'h45, 0, 8'h45, 0, 7'h45, 0, 1, 30);
        vecs[1] = mkv(1, 0, 1, 0, 8'h00, 0, 8'hA5, 1, 8'hA5, 0, 7'h45, 0, 1, 30);
        vecs[2] = mkv(0, 1, 0, 0, 8'h80, 2, 8'h12, 0, 8'h12, 0, 7'h12, 0, 3, 140);
        vecs[3] = mkv(0, 1, 0, 0, 8'hFF, 4, 8'hFF, 0, 8'hFF, 1, 7'h7F, 1, 4, 195);
        vecs[4] = mkv(1, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 8'h3C, 0, 7'h3C, 0, 1, 30);
        vecs[5] = mkv(1, 1, 1, 1, 8'h00, 0, 8'h07, 0, 8'h07, 0, 7'h07, 0, 1, 30);

        #1;
        chk("reset_outputs",
            {rd_ack, rd_done, rd_data, busy_flag, addr_counter, timeout,
             reader_active, lcd_RS, lcd_RW, lcd_E}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset asserted in the middle of the E pulse of a data read.
        @(negedge clk);
        lcd_DB_in = 8'h55; rd_rs = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        saw_e = 0;
        for (int c = 0; c < 20; c++) begin
            if (lcd_E) begin
                saw_e = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_e_high", saw_e, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_lcd_E", lcd_E, 0);
        chk("rst_async_all",
            {rd_ack, rd_done, rd_data, busy_flag, addr_counter, timeout,
             reader_active, lcd_RS, lcd_RW, lcd_E}, 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_done) dones++;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rd_done || reader_active) dones++;
        end
        chk("rst_no_done_stays_idle", dones, 0);

        vr = mkv(1, 0, 0, 0, 8'h00, 0, 8'h66, 0, 8'h66, 0, 7'h66, 0, 1, 30);
        run_vec(vr, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
